// File: rtl/uart_rx_packet_ctrl_if.sv
// Signal bundle between the UART byte receiver, the packet controller and the application.
// The controller owns the master modport. The receiver/application side uses the slave modport.
interface uart_rx_packet_ctrl_if;
  logic       Rx_Done_Sig;
  logic [7:0] Rx_Data;
  logic       Rx_En_Sig;
  logic       Data_Valid;
  logic [7:0] Data_Out;
  logic [7:0] Data_Idx;
  logic       Pkt_Done_Sig;
  logic [7:0] Pkt_Len;
  logic       Pkt_Err_Sig;
  logic [1:0] Err_Code;

  modport master (
    input  Rx_Done_Sig, Rx_Data,
    output Rx_En_Sig, Data_Valid, Data_Out, Data_Idx,
           Pkt_Done_Sig, Pkt_Len, Pkt_Err_Sig, Err_Code
  );

  modport slave (
    output Rx_Done_Sig, Rx_Data,
    input  Rx_En_Sig, Data_Valid, Data_Out, Data_Idx,
           Pkt_Done_Sig, Pkt_Len, Pkt_Err_Sig, Err_Code
  );
endinterface

// File: rtl/uart_rx_packet_ctrl.sv
// Packet controller for the UART receiver. It parses HEADER, LEN, payload and checksum frames.
// Optional inter-byte timeout: define RX_PKT_TIMEOUT_EN.
module uart_rx_packet_ctrl #(
  parameter logic [7:0]  HEADER         = 8'hAA,
  parameter int unsigned MAX_LEN        = 16,
  parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
  input  logic                 CLK,
  input  logic                 RST_n,
  input  logic                 Ctrl_En,
  uart_rx_packet_ctrl_if.master bus
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    HDR  = 3'd1,
    LEN  = 3'd2,
    DATA = 3'd3,
    SUM  = 3'd4,
    DONE = 3'd5,
    ERR  = 3'd6
  } state_t;

  localparam logic [7:0] MAX_LEN_B = 8'(MAX_LEN);

  if ((MAX_LEN < 1) || (MAX_LEN > 255)) begin : g_bad_max_len
    $error("MAX_LEN must be in 1..255");
  end
  if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be at least 2");
  end

  function automatic logic [7:0] sum8(input logic [7:0] acc, input logic [7:0] b);
    return acc + b;
  endfunction

  state_t     state_q, state_d;
  logic [7:0] len_n_q, len_n_d;
  logic [7:0] cnt_q, cnt_d;
  logic [7:0] sum_q, sum_d;
  logic       rx_en_q, rx_en_d;
  logic       dv_q, dv_d;
  logic [7:0] dout_q, dout_d;
  logic [7:0] didx_q, didx_d;
  logic       done_q, done_d;
  logic [7:0] plen_q, plen_d;
  logic       err_q, err_d;
  logic [1:0] code_q, code_d;
  logic       timeout_s;

`ifdef RX_PKT_TIMEOUT_EN
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TMAX = TW'(TIMEOUT_CYCLES - 1);
  logic [TW-1:0] timer_q, timer_d;
  logic          timing_s;

  // Inter-byte timer: runs only while a packet is in flight and restarts on each byte or state change.
  always_comb begin
    timing_s = (state_q == LEN) || (state_q == DATA) || (state_q == SUM);
    timeout_s = timing_s && !bus.Rx_Done_Sig && (timer_q == TMAX);
    if (bus.Rx_Done_Sig || (state_d != state_q) || !timing_s) begin
      timer_d = '0;
    end else begin
      timer_d = timer_q + TW'(1);
    end
  end

  // Timer register.
  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      timer_q <= '0;
    end else begin
      timer_q <= timer_d;
    end
  end
`else
  assign timeout_s = 1'b0;
`endif

  // Next-state and next-output logic. Outputs are derived from the transition, so they line up with state_q.
  always_comb begin
    state_d  = state_q;
    len_n_d  = len_n_q;
    cnt_d    = cnt_q;
    sum_d    = sum_q;
    dv_d     = 1'b0;
    dout_d   = dout_q;
    didx_d   = didx_q;
    done_d   = 1'b0;
    plen_d   = plen_q;
    err_d    = 1'b0;
    code_d   = code_q;
    if (!Ctrl_En) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: state_d = HDR;
        HDR: begin
          if (bus.Rx_Done_Sig && (bus.Rx_Data == HEADER)) begin
            state_d = LEN;
          end else begin
            state_d = HDR;
          end
        end
        LEN: begin
          if (bus.Rx_Done_Sig) begin
            if ((bus.Rx_Data == 8'd0) || (bus.Rx_Data > MAX_LEN_B)) begin
              state_d = ERR;
              err_d   = 1'b1;
              code_d  = 2'b01;
            end else begin
              state_d = DATA;
              len_n_d = bus.Rx_Data;
              cnt_d   = 8'd0;
              sum_d   = 8'd0;
            end
          end else if (timeout_s) begin
            state_d = ERR;
            err_d   = 1'b1;
            code_d  = 2'b11;
          end else begin
            state_d = LEN;
          end
        end
        DATA: begin
          if (bus.Rx_Done_Sig) begin
            dv_d   = 1'b1;
            dout_d = bus.Rx_Data;
            didx_d = cnt_q;
            sum_d  = sum8(sum_q, bus.Rx_Data);
            cnt_d  = cnt_q + 8'd1;
            if (cnt_q == (len_n_q - 8'd1)) begin
              state_d = SUM;
            end else begin
              state_d = DATA;
            end
          end else if (timeout_s) begin
            state_d = ERR;
            err_d   = 1'b1;
            code_d  = 2'b11;
          end else begin
            state_d = DATA;
          end
        end
        SUM: begin
          if (bus.Rx_Done_Sig) begin
            if (bus.Rx_Data == sum_q) begin
              state_d = DONE;
              done_d  = 1'b1;
              plen_d  = len_n_q;
            end else begin
              state_d = ERR;
              err_d   = 1'b1;
              code_d  = 2'b10;
            end
          end else if (timeout_s) begin
            state_d = ERR;
            err_d   = 1'b1;
            code_d  = 2'b11;
          end else begin
            state_d = SUM;
          end
        end
        DONE:    state_d = HDR;
        ERR:     state_d = HDR;
        default: state_d = IDLE;
      endcase
    end
    rx_en_d = (state_d == HDR) || (state_d == LEN) || (state_d == DATA) || (state_d == SUM);
  end

  // State and registered outputs.
  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      state_q <= IDLE;
      len_n_q <= 8'd0;
      cnt_q   <= 8'd0;
      sum_q   <= 8'd0;
      rx_en_q <= 1'b0;
      dv_q    <= 1'b0;
      dout_q  <= 8'd0;
      didx_q  <= 8'd0;
      done_q  <= 1'b0;
      plen_q  <= 8'd0;
      err_q   <= 1'b0;
      code_q  <= 2'b00;
    end else begin
      state_q <= state_d;
      len_n_q <= len_n_d;
      cnt_q   <= cnt_d;
      sum_q   <= sum_d;
      rx_en_q <= rx_en_d;
      dv_q    <= dv_d;
      dout_q  <= dout_d;
      didx_q  <= didx_d;
      done_q  <= done_d;
      plen_q  <= plen_d;
      err_q   <= err_d;
      code_q  <= code_d;
    end
  end

  assign bus.Rx_En_Sig    = rx_en_q;
  assign bus.Data_Valid   = dv_q;
  assign bus.Data_Out     = dout_q;
  assign bus.Data_Idx     = didx_q;
  assign bus.Pkt_Done_Sig = done_q;
  assign bus.Pkt_Len      = plen_q;
  assign bus.Pkt_Err_Sig  = err_q;
  assign bus.Err_Code     = code_q;

endmodule

// File: tb/tb_uart_rx_packet_ctrl.sv
// Directed-vector bench for uart_rx_packet_ctrl.
// Expected events go into a queue, and a negedge monitor pops the queue and compares.
module tb_uart_rx_packet_ctrl;

  localparam logic [1:0] K_DV = 2'd0;
  localparam logic [1:0] K_DONE = 2'd1;
  localparam logic [1:0] K_ERR = 2'd2;

  typedef struct {
    logic [1:0] kind;
    logic [7:0] a;
    logic [7:0] b;
  } exp_t;

  logic CLK;
  logic RST_n;
  logic Ctrl_En;
  int   passed;
  int   total;
  int   cyc;
  int   last_done_cyc;
  logic prev_done;
  exp_t sbq[$];

  uart_rx_packet_ctrl_if bus ();

`ifdef RX_PKT_TIMEOUT_EN
  uart_rx_packet_ctrl #(.HEADER(8'hAA), .MAX_LEN(16), .TIMEOUT_CYCLES(50)) dut (
`else
  uart_rx_packet_ctrl #(.HEADER(8'hAA), .MAX_LEN(16)) dut (
`endif
    .CLK    (CLK),
    .RST_n  (RST_n),
    .Ctrl_En(Ctrl_En),
    .bus    (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  always @(posedge CLK) cyc = cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total = total + 1;
    if (act === exp) begin
      passed = passed + 1;
    end else begin
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic expect_ev(input logic [1:0] kind, input logic [7:0] a, input logic [7:0] b);
    exp_t e;
    e.kind = kind;
    e.a = a;
    e.b = b;
    sbq.push_back(e);
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(posedge CLK);
    #1;
    check("rx_en_before_byte", {31'd0, bus.Rx_En_Sig}, 32'd1);
    bus.Rx_Done_Sig = 1'b1;
    bus.Rx_Data = b;
    @(posedge CLK);
    #1;
    bus.Rx_Done_Sig = 1'b0;
    repeat (2) @(posedge CLK);
  endtask

  // Monitor: each output pulse pops the next expected event and compares it.
  always @(negedge CLK) begin
    if (RST_n) begin
      if (bus.Pkt_Done_Sig && bus.Pkt_Err_Sig) begin
        check("done_err_exclusive", 32'd1, 32'd0);
      end
      if (bus.Data_Valid && bus.Pkt_Done_Sig) begin
        check("dv_done_exclusive", 32'd1, 32'd0);
      end
      if (bus.Data_Valid) begin
        if (sbq.size() == 0) begin
          check("unexpected_data_valid", {24'd0, bus.Data_Out}, 32'hFFFF_FFFF);
        end else begin
          exp_t e;
          e = sbq.pop_front();
          check("dv_kind", {30'd0, K_DV}, {30'd0, e.kind});
          check("dv_data", {24'd0, bus.Data_Out}, {24'd0, e.a});
          check("dv_idx", {24'd0, bus.Data_Idx}, {24'd0, e.b});
          check("dv_latency", {31'd0, prev_done}, 32'd1);
        end
      end
      if (bus.Pkt_Done_Sig) begin
        if (sbq.size() == 0) begin
          check("unexpected_pkt_done", {24'd0, bus.Pkt_Len}, 32'hFFFF_FFFF);
        end else begin
          exp_t e;
          e = sbq.pop_front();
          check("done_kind", {30'd0, K_DONE}, {30'd0, e.kind});
          check("done_len", {24'd0, bus.Pkt_Len}, {24'd0, e.a});
        end
      end
      if (bus.Pkt_Err_Sig) begin
        if (sbq.size() == 0) begin
          check("unexpected_pkt_err", {30'd0, bus.Err_Code}, 32'hFFFF_FFFF);
        end else begin
          exp_t e;
          e = sbq.pop_front();
          check("err_kind", {30'd0, K_ERR}, {30'd0, e.kind});
          check("err_code", {30'd0, bus.Err_Code}, {30'd0, e.a[1:0]});
          if (e.a[1:0] == 2'b11) begin
            check("timeout_cycles", cyc - last_done_cyc, 32'd50);
          end
        end
      end
      if (bus.Rx_Done_Sig) begin
        last_done_cyc = cyc + 1;
      end
      prev_done = bus.Rx_Done_Sig;
    end else begin
      prev_done = 1'b0;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    passed = 0;
    total = 0;
    cyc = 0;
    last_done_cyc = 0;
    prev_done = 1'b0;
    RST_n = 1'b0;
    Ctrl_En = 1'b0;
    bus.Rx_Done_Sig = 1'b0;
    bus.Rx_Data = 8'h00;
    repeat (3) @(posedge CLK);
    #1;
    check("rst_rx_en", {31'd0, bus.Rx_En_Sig}, 32'd0);
    check("rst_dv", {31'd0, bus.Data_Valid}, 32'd0);
    check("rst_dout", {24'd0, bus.Data_Out}, 32'd0);
    check("rst_didx", {24'd0, bus.Data_Idx}, 32'd0);
    check("rst_done", {31'd0, bus.Pkt_Done_Sig}, 32'd0);
    check("rst_len", {24'd0, bus.Pkt_Len}, 32'd0);
    check("rst_err", {31'd0, bus.Pkt_Err_Sig}, 32'd0);
    check("rst_code", {30'd0, bus.Err_Code}, 32'd0);
    RST_n = 1'b1;
    @(posedge CLK);
    #1;
    check("idle_rx_en", {31'd0, bus.Rx_En_Sig}, 32'd0);
    Ctrl_En = 1'b1;

    // Test 1: good packet with three payload bytes.
    expect_ev(K_DV, 8'h11, 8'd0);
    expect_ev(K_DV, 8'h22, 8'd1);
    expect_ev(K_DV, 8'h33, 8'd2);
    expect_ev(K_DONE, 8'd3, 8'd0);
    send_byte(8'hAA); send_byte(8'h03); send_byte(8'h11);
    send_byte(8'h22); send_byte(8'h33); send_byte(8'h66);

    // Test 2: checksum mismatch, followed by a good one-byte packet.
    expect_ev(K_DV, 8'h11, 8'd0);
    expect_ev(K_DV, 8'h22, 8'd1);
    expect_ev(K_DV, 8'h33, 8'd2);
    expect_ev(K_ERR, 8'd2, 8'd0);
    send_byte(8'hAA); send_byte(8'h03); send_byte(8'h11);
    send_byte(8'h22); send_byte(8'h33); send_byte(8'h67);
    expect_ev(K_DV, 8'h05, 8'd0);
    expect_ev(K_DONE, 8'd1, 8'd0);
    send_byte(8'hAA); send_byte(8'h01); send_byte(8'h05); send_byte(8'h05);

    // Test 3: zero length, then a length above MAX_LEN.
    expect_ev(K_ERR, 8'd1, 8'd0);
    send_byte(8'hAA); send_byte(8'h00);
    expect_ev(K_ERR, 8'd1, 8'd0);
    send_byte(8'hAA); send_byte(8'h11);

    // Test 4: junk before the header is ignored.
    expect_ev(K_DV, 8'h01, 8'd0);
    expect_ev(K_DV, 8'h02, 8'd1);
    expect_ev(K_DONE, 8'd2, 8'd0);
    send_byte(8'h55); send_byte(8'h12); send_byte(8'hAA);
    send_byte(8'h02); send_byte(8'h01); send_byte(8'h02); send_byte(8'h03);

    // Test 5: abort mid-packet with Ctrl_En low, then recover.
    expect_ev(K_DV, 8'h01, 8'd0);
    send_byte(8'hAA); send_byte(8'h04); send_byte(8'h01);
    @(posedge CLK);
    #1;
    Ctrl_En = 1'b0;
    @(posedge CLK);
    #1;
    check("abort_rx_en", {31'd0, bus.Rx_En_Sig}, 32'd0);
    Ctrl_En = 1'b1;
    expect_ev(K_DV, 8'h09, 8'd0);
    expect_ev(K_DONE, 8'd1, 8'd0);
    send_byte(8'hAA); send_byte(8'h01); send_byte(8'h09); send_byte(8'h09);

    // Test 6: silence mid-packet.
    expect_ev(K_DV, 8'h01, 8'd0);
`ifdef RX_PKT_TIMEOUT_EN
    expect_ev(K_ERR, 8'd3, 8'd0);
`endif
    send_byte(8'hAA); send_byte(8'h02); send_byte(8'h01);
    repeat (1000) @(posedge CLK);
    #1;

    check("len_held", {24'd0, bus.Pkt_Len}, 32'd1);
`ifdef RX_PKT_TIMEOUT_EN
    check("code_held", {30'd0, bus.Err_Code}, 32'd3);
`else
    check("code_held", {30'd0, bus.Err_Code}, 32'd1);
    check("rx_en_waiting", {31'd0, bus.Rx_En_Sig}, 32'd1);
`endif
    check("scoreboard_empty", sbq.size(), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
